// File: rtl/windowed_rf_pkg.sv
// Shared types and address-translation helpers for the windowed register file.
package windowed_rf_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SPILL = 2'd1,
        FILL  = 2'd2
    } state_t;

    // Default configuration; the top level takes these as parameter defaults.
    localparam int DEF_M = 4;
    localparam int DEF_N = 4;
    localparam int DEF_F = 4;

    // Physical register count: globals plus an IN+LOCAL block per window.
    function automatic int nphys(input int m, input int n, input int f);
        return m + 2 * n * f;
    endfunction

    // Registers moved per spilled or filled frame (IN + LOCAL).
    function automatic int frame_len(input int n);
        return 2 * n;
    endfunction

    // Logical-to-physical translation for window cwp; returns -1 when unmapped.
    // OUT of window w aliases IN of window (w+1) mod F.
    function automatic int phys_idx(input int cwp, input int laddr,
                                    input int m, input int n, input int f);
        int p;
        if (laddr < 2 * n)
            p = m + 2 * n * cwp + laddr;
        else if (laddr < 3 * n)
            p = m + 2 * n * ((cwp + 1) % f) + laddr - 2 * n;
        else if (laddr < 3 * n + m)
            p = laddr - 3 * n;
        else
            p = -1;
        return p;
    endfunction

endpackage

// File: rtl/windowed_rf_spill_map.sv
// Combinational logical->physical register translation with an in-range flag.
module rf_window_map
    import windowed_rf_pkg::*;
#(
    parameter int M     = DEF_M,
    parameter int N     = DEF_N,
    parameter int F     = DEF_F,
    parameter int WW    = $clog2(F),
    parameter int NADDR = $clog2(3 * N + M),
    parameter int PW    = $clog2(nphys(M, N, F))
) (
    input  logic [WW-1:0]    win,
    input  logic [NADDR-1:0] laddr,
    output logic [PW-1:0]    phys,
    output logic             valid
);

    // Translate through the shared helper; unmapped addresses report index 0.
    always_comb begin
        int p;
        p     = phys_idx(int'(win), int'(laddr), M, N, F);
        valid = (p >= 0);
        phys  = valid ? PW'(p) : '0;
    end

endmodule

// File: rtl/windowed_rf_spill.sv
// Windowed register file with NRD registered read ports, one write port and a
// spill/fill engine that streams whole frames to/from an external stack.
module windowed_rf_spill
    import windowed_rf_pkg::*;
#(
    parameter int NBIT     = 64,
    parameter int M        = DEF_M,
    parameter int N        = DEF_N,
    parameter int F        = DEF_F,
    parameter int NRD      = 2,
    parameter int MAXSPILL = 16,
    localparam int NADDR   = $clog2(3 * N + M)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic [NRD-1:0]             rd,
    input  logic [NRD-1:0][NADDR-1:0]  add_rd,
    output logic [NRD-1:0][NBIT-1:0]   out,
    input  logic                       wr,
    input  logic [NADDR-1:0]           add_wr,
    input  logic [NBIT-1:0]            datain,
    input  logic                       subcall,
    input  logic                       subreturn,
    output logic [NBIT-1:0]            busout,
    output logic                       spill_valid,
    input  logic                       spill_ready,
    input  logic [NBIT-1:0]            busin,
    output logic                       fill_req,
    input  logic                       fill_valid,
    output logic                       busy,
    output logic                       err
);

    localparam int NPHYS = nphys(M, N, F);
    localparam int FRAME = frame_len(N);
    localparam int PW    = $clog2(NPHYS);
    localparam int WW    = $clog2(F);
    localparam int SW    = $clog2(MAXSPILL + 1);
    localparam int BW    = $clog2(FRAME);

    state_t            state, state_next;
    logic [NBIT-1:0]   regs [NPHYS];
    logic [NBIT-1:0]   out_reg [NRD];
    logic [WW-1:0]     cwp, swp, occ;
    logic [SW-1:0]     sd;
    logic [BW-1:0]     beat;

    logic op_ok, call_op, ret_op, wr_en, spill_fire, fill_fire, last_beat;
    logic step_up, step_dn, start_spill, start_fill, spill_done, fill_done, err_next;
    logic [PW-1:0]    wr_phys, sf_phys;
    logic             wr_valid, sf_valid;
    logic [WW-1:0]    sf_win;
    logic [NADDR-1:0] sf_laddr;

    function automatic logic [WW-1:0] win_inc(input logic [WW-1:0] w);
        return (w == WW'(F - 1)) ? '0 : w + WW'(1);
    endfunction

    function automatic logic [WW-1:0] win_dec(input logic [WW-1:0] w);
        return (w == '0) ? WW'(F - 1) : w - WW'(1);
    endfunction

    assign busy       = (state != IDLE);
    assign fill_req   = (state == FILL);
    assign op_ok      = enable && (state == IDLE);
    assign call_op    = op_ok && subcall && !subreturn;
    assign ret_op     = op_ok && subreturn && !subcall;
    assign wr_en      = op_ok && wr;
    assign spill_fire = (state == SPILL) && spill_valid && spill_ready;
    assign fill_fire  = (state == FILL) && fill_valid;
    assign last_beat  = (beat == BW'(FRAME - 1));

    rf_window_map #(.M(M), .N(N), .F(F), .WW(WW), .NADDR(NADDR), .PW(PW)) u_wr_map (
        .win(cwp), .laddr(add_wr), .phys(wr_phys), .valid(wr_valid)
    );

    // Spill walks the frame forwards (pointing at the next beat to load);
    // fill walks the frame below SWP backwards (pointing at the beat being written).
    always_comb begin
        sf_win   = (state == FILL) ? win_dec(swp) : swp;
        sf_laddr = '0;
        if (state == SPILL)
            sf_laddr = NADDR'(beat) + NADDR'(1);
        else if (state == FILL)
            sf_laddr = NADDR'(FRAME - 1) - NADDR'(beat);
    end

    rf_window_map #(.M(M), .N(N), .F(F), .WW(WW), .NADDR(NADDR), .PW(PW)) u_sf_map (
        .win(sf_win), .laddr(sf_laddr), .phys(sf_phys), .valid(sf_valid)
    );

    // Read ports: registered data with write-through bypass, holding when idle.
    for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
        logic [PW-1:0] rd_phys;
        logic          rd_valid;

        rf_window_map #(.M(M), .N(N), .F(F), .WW(WW), .NADDR(NADDR), .PW(PW)) u_rd_map (
            .win(cwp), .laddr(add_rd[gi]), .phys(rd_phys), .valid(rd_valid)
        );

        // Load the port register on an accepted read strobe.
        always_ff @(posedge clk or posedge reset) begin
            if (reset)
                out_reg[gi] <= '0;
            else if (rd[gi] && op_ok) begin
                if (!rd_valid)
                    out_reg[gi] <= '0;
                else if (wr_en && wr_valid && (wr_phys == rd_phys))
                    out_reg[gi] <= datain;
                else
                    out_reg[gi] <= regs[rd_phys];
            end
        end

        assign out[gi] = out_reg[gi];
    end

    // Register array: port writes when idle, fill beats while filling.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NPHYS; i++)
                regs[i] <= '0;
        end else if (wr_en && wr_valid)
            regs[wr_phys] <= datain;
        else if (fill_fire && sf_valid)
            regs[sf_phys] <= busin;
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // FSM next state and window-operation decode.
    always_comb begin
        state_next  = state;
        step_up     = 1'b0;
        step_dn     = 1'b0;
        start_spill = 1'b0;
        start_fill  = 1'b0;
        spill_done  = 1'b0;
        fill_done   = 1'b0;
        err_next    = 1'b0;
        case (state)
            IDLE: begin
                if (call_op) begin
                    if (occ < WW'(F - 1))
                        step_up = 1'b1;
                    else if (sd < SW'(MAXSPILL)) begin
                        state_next  = SPILL;
                        start_spill = 1'b1;
                    end else
                        err_next = 1'b1;
                end else if (ret_op) begin
                    if (occ > WW'(1))
                        step_dn = 1'b1;
                    else if (sd != '0) begin
                        state_next = FILL;
                        start_fill = 1'b1;
                    end else
                        err_next = 1'b1;
                end
            end
            SPILL: begin
                if (spill_fire && last_beat) begin
                    state_next = IDLE;
                    spill_done = 1'b1;
                end
            end
            FILL: begin
                if (fill_fire && last_beat) begin
                    state_next = IDLE;
                    fill_done  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Window pointers, occupancy and spilled-frame count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cwp <= '0;
            swp <= '0;
            occ <= WW'(1);
            sd  <= '0;
            err <= 1'b0;
        end else begin
            err <= err_next;
            if (step_up || spill_done)
                cwp <= win_inc(cwp);
            else if (step_dn || fill_done)
                cwp <= win_dec(cwp);
            if (step_up)
                occ <= occ + WW'(1);
            else if (step_dn)
                occ <= occ - WW'(1);
            if (spill_done) begin
                swp <= win_inc(swp);
                sd  <= sd + SW'(1);
            end else if (fill_done) begin
                swp <= win_dec(swp);
                sd  <= sd - SW'(1);
            end
        end
    end

    // Beat counter and registered spill bus, held stable until accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            beat        <= '0;
            spill_valid <= 1'b0;
            busout      <= '0;
        end else begin
            if (start_spill || start_fill)
                beat <= '0;
            else if (spill_fire || fill_fire)
                beat <= beat + BW'(1);
            if (start_spill)
                spill_valid <= 1'b1;
            else if (spill_done)
                spill_valid <= 1'b0;
            if (start_spill || (spill_fire && !last_beat))
                busout <= sf_valid ? regs[sf_phys] : '0;
        end
    end

endmodule

// File: tb/tb_windowed_rf_spill.sv
// Directed bench for windowed_rf_spill: scoreboard of expected read/spill data.
module tb_windowed_rf_spill;

    localparam int NBIT  = 64;
    localparam int NRD   = 2;
    localparam int NADDR = 4;

    logic                      clk = 1'b0;
    logic                      reset, enable, wr, subcall, subreturn;
    logic                      spill_ready, fill_valid;
    logic [NRD-1:0]            rd;
    logic [NRD-1:0][NADDR-1:0] add_rd;
    logic [NRD-1:0][NBIT-1:0]  out;
    logic [NADDR-1:0]          add_wr;
    logic [NBIT-1:0]           datain, busout, busin;
    logic                      spill_valid, fill_req, busy, err;

    int checks   = 0;
    int failures = 0;
    logic [NBIT-1:0] exp_q [$];
    string           tag_q [$];

    windowed_rf_spill dut (
        .clk(clk), .reset(reset), .enable(enable), .rd(rd), .add_rd(add_rd), .out(out),
        .wr(wr), .add_wr(add_wr), .datain(datain), .subcall(subcall), .subreturn(subreturn),
        .busout(busout), .spill_valid(spill_valid), .spill_ready(spill_ready),
        .busin(busin), .fill_req(fill_req), .fill_valid(fill_valid), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [NBIT-1:0] obs, input logic [NBIT-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
        $display("check %-16s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    task automatic sb_push(input string tag, input logic [NBIT-1:0] v);
        exp_q.push_back(v);
        tag_q.push_back(tag);
    endtask

    task automatic sb_pop(input logic [NBIT-1:0] obs);
        string t;
        logic [NBIT-1:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL scoreboard_empty observed=%0h expected=none", obs);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            check(t, obs, e);
        end
    endtask

    task automatic do_write(input logic [NADDR-1:0] a, input logic [NBIT-1:0] d);
        wr = 1'b1; add_wr = a; datain = d;
        tick();
        wr = 1'b0;
    endtask

    task automatic read1(input logic [NADDR-1:0] a, input logic [NBIT-1:0] e, input string tag);
        rd = 2'b01; add_rd[0] = a;
        sb_push(tag, e);
        tick();
        rd = '0;
        sb_pop(out[0]);
    endtask

    task automatic read2(input logic [NADDR-1:0] a0, input logic [NBIT-1:0] e0,
                         input logic [NADDR-1:0] a1, input logic [NBIT-1:0] e1, input string tag);
        rd = 2'b11; add_rd[0] = a0; add_rd[1] = a1;
        sb_push({tag, "_p0"}, e0);
        sb_push({tag, "_p1"}, e1);
        tick();
        rd = '0;
        sb_pop(out[0]);
        sb_pop(out[1]);
    endtask

    task automatic do_call();
        subcall = 1'b1;
        tick();
        subcall = 1'b0;
    endtask

    task automatic do_ret();
        subreturn = 1'b1;
        tick();
        subreturn = 1'b0;
    endtask

    initial begin
        int beats;
        int c;
        int k;
        logic [NBIT-1:0] held;

        reset = 1'b1; enable = 1'b0; wr = 1'b0; subcall = 1'b0; subreturn = 1'b0;
        spill_ready = 1'b0; fill_valid = 1'b0; rd = '0; add_rd = '0;
        add_wr = '0; datain = '0; busin = '0;
        tick();
        tick();

        // Reset state
        check("rst_out0", out[0], 0);
        check("rst_out1", out[1], 0);
        check("rst_busout", busout, 0);
        check("rst_spill_valid", {63'b0, spill_valid}, 0);
        check("rst_fill_req", {63'b0, fill_req}, 0);
        check("rst_busy", {63'b0, busy}, 0);
        check("rst_err", {63'b0, err}, 0);
        reset = 1'b0;
        enable = 1'b1;
        tick();

        // Underflow right after reset, and simultaneous call+return
        do_write(0, 64'h77);
        do_ret();
        check("underflow_err", {63'b0, err}, 1);
        tick();
        check("err_one_cycle", {63'b0, err}, 0);
        read1(0, 64'h77, "cwp_unchanged");
        subcall = 1'b1; subreturn = 1'b1;
        tick();
        subcall = 1'b0; subreturn = 1'b0;
        check("both_no_err", {63'b0, err}, 0);
        read1(0, 64'h77, "both_noop");

        // Globals are visible from every window
        do_write(12, 64'hA5);
        do_call();
        read1(12, 64'hA5, "global_read");

        // Same-cycle write/read bypass
        wr = 1'b1; add_wr = 1; datain = 64'h33;
        rd = 2'b01; add_rd[0] = 1;
        sb_push("bypass", 64'h33);
        tick();
        wr = 1'b0; rd = '0;
        sb_pop(out[0]);

        // OUT of caller aliases IN of callee
        do_write(8, 64'h11);
        do_call();
        read1(0, 64'h11, "out_to_in");
        do_ret();
        read1(8, 64'h11, "in_to_out");
        do_ret();

        // Overflow spill of window 0 with backpressure
        for (int i = 0; i < 8; i++)
            do_write(NADDR'(i), 64'h100 + 64'(i));
        do_call();
        do_call();
        read1(12, 64'hA5, "pre_spill_read");
        do_call();
        check("spill_busy", {63'b0, busy}, 1);
        for (int i = 0; i < 8; i++)
            sb_push("spill_beat", 64'h100 + 64'(i));
        rd = 2'b01; add_rd[0] = 0;
        beats = 0;
        c = 0;
        while (beats < 8 && c < 64) begin
            spill_ready = (c % 2 == 1);
            if (spill_ready) begin
                check("spill_valid", {63'b0, spill_valid}, 1);
                sb_pop(busout);
                beats++;
                tick();
            end else begin
                held = busout;
                tick();
                check("spill_hold", busout, held);
            end
            c++;
        end
        spill_ready = 1'b0;
        rd = '0;
        if (beats < 8) begin
            checks++;
            failures++;
            $error("FAIL spill_timeout observed=%0d expected=8", beats);
        end
        check("spill_done_busy", {63'b0, busy}, 0);
        check("spill_done_valid", {63'b0, spill_valid}, 0);
        check("rd_during_busy", out[0], 64'hA5);

        // Clobber window 0's IN through the aliased OUT of window 3
        for (int i = 8; i < 12; i++)
            do_write(NADDR'(i), 64'hDEAD0 + 64'(i));
        read1(8, 64'hDEAD8, "clobber_read");

        // Underflow fill restores window 0
        do_ret();
        do_ret();
        do_ret();
        check("fill_busy", {63'b0, busy}, 1);
        k = 0;
        c = 0;
        while (k < 8 && c < 64) begin
            fill_valid = (c % 3 != 2);
            busin = 64'h107 - 64'(k);
            if (fill_valid)
                check("fill_req", {63'b0, fill_req}, 1);
            tick();
            if (fill_valid)
                k++;
            c++;
        end
        fill_valid = 1'b0;
        if (k < 8) begin
            checks++;
            failures++;
            $error("FAIL fill_timeout observed=%0d expected=8", k);
        end
        check("fill_done_busy", {63'b0, busy}, 0);
        check("fill_done_req", {63'b0, fill_req}, 0);
        for (int i = 0; i < 4; i++)
            read2(NADDR'(i), 64'h100 + 64'(i), NADDR'(i + 4), 64'h104 + 64'(i), "fill_read");
        do_ret();
        check("underflow_sd0", {63'b0, err}, 1);
        tick();

        // Reset in the middle of a spill
        do_call();
        do_call();
        read2(12, 64'hA5, 0, 64'h11, "pre_abort_read");
        do_call();
        spill_ready = 1'b1;
        tick();
        tick();
        tick();
        check("mid_spill_busy", {63'b0, busy}, 1);
        #1 reset = 1'b1;
        #1;
        check("abort_spill_valid", {63'b0, spill_valid}, 0);
        check("abort_busy", {63'b0, busy}, 0);
        check("abort_out0", out[0], 0);
        check("abort_out1", out[1], 0);
        check("abort_busout", busout, 0);
        #1 reset = 1'b0;
        spill_ready = 1'b0;
        tick();
        read2(0, 0, 12, 0, "post_reset_read");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
